// File: rtl/amp_cal_if.sv
// Control/status bundle between the tile pins and the amplifier calibration sequencer.
interface amp_cal_if #(
  parameter int TRIM_W = 5
) ();
  logic              start;
  logic              stop;
  logic              cmp_in;
  logic              bgr_en;
  logic              amp_en;
  logic [TRIM_W-1:0] trim;
  logic              busy;
  logic              done;
  logic              cal_valid;

  modport master (
    output start, stop, cmp_in,
    input  bgr_en, amp_en, trim, busy, done, cal_valid
  );

  modport slave (
    input  start, stop, cmp_in,
    output bgr_en, amp_en, trim, busy, done, cal_valid
  );
endinterface

// File: rtl/amp_cal_seq.sv
// Bandgap/amplifier power-up sequencer with SAR offset-trim search.
// Optional AMP_CAL_MAJ_EN: decision bit becomes a 2-of-3 majority over the last three wait cycles.
module amp_cal_seq #(
  parameter int TRIM_W     = 5,
  parameter int SETTLE_CYC = 1024,
  parameter int CMP_WAIT   = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  amp_cal_if.slave  bus
);

  localparam int CNT_MAX = (SETTLE_CYC > CMP_WAIT) ? SETTLE_CYC : CMP_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = $clog2(TRIM_W);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD   = CNT_W'(CMP_WAIT - 1);
  localparam logic [IDX_W-1:0] IDX_TOP     = IDX_W'(TRIM_W - 1);

  typedef enum logic [2:0] {
    OFF, BGR_SETTLE, AMP_SETTLE, SAR_SET, SAR_WAIT, SAR_DECIDE, RUN
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [TRIM_W-1:0] trim_q;
  logic [TRIM_W-1:0] bit_mask;
  logic              sync_p0;
  logic              cmp_s;
  logic              decision;
  logic              bgr_q, amp_q, busy_q, done_q, valid_q;

  assign bit_mask = TRIM_W'(1) << idx;

  // cmp_in is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      cmp_s   <= 1'b0;
    end else begin
      sync_p0 <= bus.cmp_in;
      cmp_s   <= sync_p0;
    end
  end

`ifdef AMP_CAL_MAJ_EN
  logic [2:0] maj_hist;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maj_hist <= '0;
    end else if (state == SAR_WAIT && cnt <= CNT_W'(2)) begin
      maj_hist <= {maj_hist[1:0], cmp_s};
    end
  end

  assign decision = maj3(maj_hist);
`else
  assign decision = cmp_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= OFF;
      cnt     <= '0;
      idx     <= '0;
      trim_q  <= '0;
      bgr_q   <= 1'b0;
      amp_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop) begin
        // trim deliberately keeps whatever code the amplifier last saw
        state   <= OFF;
        bgr_q   <= 1'b0;
        amp_q   <= 1'b0;
        busy_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        case (state)
          OFF, RUN: begin
            if (bus.start) begin
              state   <= BGR_SETTLE;
              cnt     <= SETTLE_LOAD;
              valid_q <= 1'b0;
              bgr_q   <= 1'b1;
              amp_q   <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
          BGR_SETTLE: begin
            if (cnt == '0) begin
              state <= AMP_SETTLE;
              cnt   <= SETTLE_LOAD;
              amp_q <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          AMP_SETTLE: begin
            if (cnt == '0) begin
              state  <= SAR_SET;
              trim_q <= '0;
              idx    <= IDX_TOP;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          SAR_SET: begin
            trim_q <= trim_q | bit_mask;
            cnt    <= WAIT_LOAD;
            state  <= SAR_WAIT;
          end
          SAR_WAIT: begin
            if (cnt == '0) state <= SAR_DECIDE;
            else           cnt   <= cnt - 1'b1;
          end
          SAR_DECIDE: begin
            if (!decision) trim_q <= trim_q & ~bit_mask;
            if (idx == '0) begin
              state   <= RUN;
              done_q  <= 1'b1;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              idx   <= idx - 1'b1;
              state <= SAR_SET;
            end
          end
          default: state <= OFF;
        endcase
      end
    end
  end

  assign bus.bgr_en    = bgr_q;
  assign bus.amp_en    = amp_q;
  assign bus.trim      = trim_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cal_valid = valid_q;

endmodule

// File: tb/tb_amp_cal_seq.sv
// Bench for amp_cal_seq: per-cycle behavioural model plus directed and randomized calibration runs.
module tb_amp_cal_seq;
  localparam int TRIM_W     = 5;
  localparam int SETTLE_CYC = 8;
  localparam int CMP_WAIT   = 4;
  localparam int BIT_CYC    = CMP_WAIT + 2;
  localparam int TOT        = 2 * SETTLE_CYC + TRIM_W * BIT_CYC;
  localparam int CODE_MAX   = (1 << TRIM_W) - 1;
  localparam int M_OFF = 0, M_CAL = 1, M_RUN = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   thr = 19;
  logic glitch = 1'b0;
  int   next_final = -1;

  int n_chk = 0;
  int n_fail = 0;

  // model state: mode, edges since accepted start, and the outputs it implies
  int m_mode = M_OFF, m_k = 0, m_final = 0;
  int m_trim = 0, m_cv = 0, m_done = 0;

  amp_cal_if #(.TRIM_W(TRIM_W)) bus ();

  amp_cal_seq #(
    .TRIM_W    (TRIM_W),
    .SETTLE_CYC(SETTLE_CYC),
    .CMP_WAIT  (CMP_WAIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Comparator: amplifier output says "keep" while the trial code is at or below the threshold
  assign bus.cmp_in = (int'(bus.trim) <= thr) ^ glitch;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rn, input logic st, input logic sp);
    int r, d, topmask;
    m_done = 0;
    if (!rn) begin
      m_mode = M_OFF; m_trim = 0; m_cv = 0;
    end else if (sp) begin
      m_mode = M_OFF; m_cv = 0;
    end else if (m_mode != M_CAL) begin
      if (st) begin
        m_mode  = M_CAL;
        m_k     = 0;
        m_cv    = 0;
        m_final = (next_final >= 0) ? next_final : ((thr > CODE_MAX) ? CODE_MAX : thr);
      end
    end else begin
      m_k++;
      if (m_k == TOT) begin
        m_mode = M_RUN; m_done = 1; m_cv = 1; m_trim = m_final;
      end
    end
    // during the search: decided upper bits equal the result, plus the current trial bit
    if (m_mode == M_CAL && m_k >= 2 * SETTLE_CYC) begin
      r = m_k - 2 * SETTLE_CYC;
      d = r / BIT_CYC;
      topmask = ((1 << d) - 1) << (TRIM_W - d);
      m_trim = (m_final & topmask) | (((r % BIT_CYC) != 0) ? (1 << (TRIM_W - 1 - d)) : 0);
    end
  endtask

  always @(posedge clk) begin : compare
    logic s_rn, s_st, s_sp;
    s_rn = rst_n;
    s_st = bus.start;
    s_sp = bus.stop;
    model_step(s_rn, s_st, s_sp);
    #2;
    chk("trim",      int'(bus.trim),      m_trim);
    chk("bgr_en",    int'(bus.bgr_en),    (m_mode != M_OFF) ? 1 : 0);
    chk("amp_en",    int'(bus.amp_en),    (m_mode == M_RUN || (m_mode == M_CAL && m_k >= SETTLE_CYC)) ? 1 : 0);
    chk("busy",      int'(bus.busy),      (m_mode == M_CAL) ? 1 : 0);
    chk("done",      int'(bus.done),      m_done);
    chk("cal_valid", int'(bus.cal_valid), m_cv);
  end

  task automatic start_pulse();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int k0, output int lat);
    lat = -1;
    for (int k = k0 + 1; k <= k0 + 200; k++) begin
      @(posedge clk);
      #2;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int sk;
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    // reset
    repeat (3) @(posedge clk);
    #2;
    chk("rst_trim", int'(bus.trim), 0);
    chk("rst_bgr", int'(bus.bgr_en), 0);
    chk("rst_valid", int'(bus.cal_valid), 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #2;

    // power-up and convergence to 19
    thr = 19;
    start_pulse();
    repeat (7) @(posedge clk);
    #2;
    chk("pwr_bgr_k7", int'(bus.bgr_en), 1);
    chk("pwr_amp_k7", int'(bus.amp_en), 0);
    @(posedge clk);
    #2;
    chk("pwr_amp_k8", int'(bus.amp_en), 1);
    wait_done(8, lat);
    chk("done_latency", lat, 46);
    chk("trim_19", int'(bus.trim), 19);
    chk("valid_19", int'(bus.cal_valid), 1);

    // threshold extremes
    thr = 0;
    start_pulse();
    wait_done(0, lat);
    chk("done_latency_0", lat, 46);
    chk("trim_0", int'(bus.trim), 0);
    thr = 31;
    start_pulse();
    wait_done(0, lat);
    chk("trim_31", int'(bus.trim), 31);

    // recalibration from RUN with start pulses while busy
    thr = 19;
    start_pulse();
    chk("recal_amp", int'(bus.amp_en), 0);
    chk("recal_bgr", int'(bus.bgr_en), 1);
    chk("recal_valid", int'(bus.cal_valid), 0);
    repeat (4) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(5, lat);
    chk("recal_latency", lat, 46);
    chk("recal_trim", int'(bus.trim), 19);

    // stop during the third SAR_WAIT
    start_pulse();
    repeat (30) @(posedge clk);
    #1 bus.stop = 1'b1;
    @(posedge clk);
    #1 bus.stop = 1'b0;
    #1;
    chk("stop_bgr", int'(bus.bgr_en), 0);
    chk("stop_busy", int'(bus.busy), 0);
    chk("stop_trim", int'(bus.trim), 20);
    repeat (TOT) @(posedge clk);
    #1;

    // start+stop together in OFF, then in RUN
    bus.start = 1'b1; bus.stop = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.stop = 1'b0;
    #1 chk("ss_off_busy", int'(bus.busy), 0);
    start_pulse();
    wait_done(0, lat);
    bus.start = 1'b1; bus.stop = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.stop = 1'b0;
    #1 chk("ss_run_bgr", int'(bus.bgr_en), 0);
    chk("ss_run_amp", int'(bus.amp_en), 0);

    // one-cycle comparator glitch during the MSB trial
`ifdef AMP_CAL_MAJ_EN
    next_final = 19;
`else
    next_final = 15;
`endif
    start_pulse();
`ifdef AMP_CAL_MAJ_EN
    repeat (18) @(posedge clk);
`else
    repeat (19) @(posedge clk);
`endif
    #1 glitch = 1'b1;
    @(posedge clk);
    #1 glitch = 1'b0;
    wait_done(0, lat);
    chk("glitch_trim", int'(bus.trim), next_final);
    next_final = -1;

    // asynchronous reset in the middle of a calibration
    start_pulse();
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_trim", int'(bus.trim), 0);
    chk("arst_busy", int'(bus.busy), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // randomized thresholds, start noise and occasional stops
    for (int it = 0; it < 15; it++) begin
      thr = $urandom_range(0, 40);
      sk  = ($urandom % 4 == 0) ? $urandom_range(1, TOT + 3) : -1;
      start_pulse();
      for (int k = 1; k <= TOT + 4; k++) begin
        @(posedge clk);
        #1;
        bus.start = (k < TOT - 1) && ($urandom % 5 == 0);
        bus.stop  = (k == sk);
      end
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      repeat (TOT + 5) @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/amp_cal_seq.md
# amp_cal_seq

Digital power-up sequencer and offset-trim controller for the on-die differential amplifier and bandgap reference. On `start` it enables the bandgap, waits for it to settle, enables the amplifier bias, waits again, then runs a successive-approximation (SAR) search on the amplifier offset-trim code. The search uses the amplifier output, fed back as a comparator bit, as its decision input. The block sits in the digital half of the tile, between the `ui_in`/`uo_out` pins and the analog enable/trim controls.

## Interface
Parameters:
- `TRIM_W`, 5, width of the offset-trim code (≥2)
- `SETTLE_CYC`, 1024, cycles each of the bandgap and amplifier settle phases last (≥2)
- `CMP_WAIT`, 16, cycles the comparator is allowed to settle per SAR bit (≥3)

Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `start`  in  1  level; sampled each cycle, begins a calibration
- `stop`  in  1  level; forces power-down from any state
- `cmp_in`  in  1  asynchronous comparator bit from amplifier output; 1 = keep trial bit
- `bgr_en`  out  1  bandgap enable
- `amp_en`  out  1  amplifier bias enable
- `trim`  out  TRIM_W  offset-trim code to the amplifier
- `busy`  out  1  calibration in progress
- `done`  out  1  one-cycle pulse at end of calibration
- `cal_valid`  out  1  `trim` holds a completed result

## Operation
- `cmp_in` always passes through a 2-flop synchronizer, giving `cmp_s`.
- States: OFF, BGR_SETTLE, AMP_SETTLE, SAR_SET, SAR_WAIT, SAR_DECIDE, RUN.
- **Reset:** state OFF. All outputs are 0, `trim` = 0, the bit index is 0, and the counter is 0.
- **OFF:**
  - `bgr_en`=`amp_en`=0.
  - `start` → BGR_SETTLE; the counter loads SETTLE_CYC-1 and `cal_valid` clears.
- **BGR_SETTLE:**
  - `bgr_en`=1, `amp_en`=0, `busy`=1.
  - The counter decrements each cycle. At 0 → AMP_SETTLE with the counter reloaded to SETTLE_CYC-1.
- **AMP_SETTLE:**
  - `bgr_en`=`amp_en`=1.
  - At counter 0 → SAR_SET; `trim` clears and the bit index is set to TRIM_W-1.
- **SAR_SET (1 cycle):**
  - Sets `trim[idx]`=1.
  - → SAR_WAIT with the counter loaded to CMP_WAIT-1.
- **SAR_WAIT:** counts down; at 0 → SAR_DECIDE.
- **SAR_DECIDE (1 cycle):**
  - If the decision bit is 0, clear `trim[idx]`; otherwise keep it.
  - If idx=0 → RUN, pulse `done`, set `cal_valid`.
  - Otherwise decrement idx → SAR_SET.
- **RUN:**
  - `bgr_en`=`amp_en`=1, `busy`=0, and `trim` is held.
  - `start` → BGR_SETTLE: `amp_en` drops, `bgr_en` stays 1, and `cal_valid` clears.
- **start handling:** `start` is ignored while `busy`. It is level-sampled, so a held `start` in RUN restarts calibration every time.
- **stop:**
  - In any state, the next state is OFF.
  - `bgr_en`, `amp_en`, `busy` and `cal_valid` clear; `trim` retains its value.
  - `stop` and `start` in the same cycle: `stop` wins.
  - `stop` held: the block remains in OFF.
- **Mid-operation reset:** asynchronously returns to the reset values, with no partial result kept.
- **Trial visibility:** `trim` shows the trial code during SAR_SET/SAR_WAIT, so the analog side sees each trial.

## Timing
- All outputs are registered, and state changes happen on the rising `clk` edge.
- If `start` is sampled high at edge 0:
  - BGR_SETTLE occupies edges 1..SETTLE_CYC.
  - `done` is high in the cycle after edge 2·SETTLE_CYC + TRIM_W·(CMP_WAIT+2).
  - `busy` falls in that same cycle.
- Decision sample: `cmp_s` in the SAR_DECIDE cycle, which reflects `cmp_in` at least 2 cycles earlier. CMP_WAIT ≥ 3 therefore guarantees the decision follows the trial code.
- `done` is exactly 1 cycle wide. `cal_valid` rises in the same cycle as `done`.

## Configuration
- `AMP_CAL_MAJ_EN` defined:
  - The decision bit is the 2-of-3 majority of `cmp_s` sampled on the last three cycles of SAR_WAIT, with counter values 2, 1 and 0.
  - Latency is unchanged.
- Not defined: the decision bit is the single `cmp_s` value in the SAR_DECIDE cycle, and the majority registers are absent.

## Test plan
All tests use TRIM_W=5, SETTLE_CYC=8, CMP_WAIT=4.
- **Power-up sequence:** reset, then a 1-cycle `start` → `bgr_en`=1 for cycles 1–8 with `amp_en`=0; `amp_en`=1 from cycle 9; `busy`=1 throughout.
- **SAR convergence:** comparator model `cmp_in`=(`trim`≤19) → `done` pulse at cycle 46, `trim`=5'd19, `cal_valid`=1, enables stay 1. Repeat with threshold 0 → 0 and threshold 31 → 31.
- **stop mid-SAR:** assert `stop` during the 3rd SAR_WAIT → next cycle all enables, `busy` and `cal_valid` are 0; `trim` keeps its trial value; no `done`.
- **Simultaneous start+stop:** both asserted in OFF → remains OFF; both asserted in RUN → OFF.
- **Recalibration and busy lockout:** `start` in RUN → `amp_en` drops, `bgr_en` stays 1, `cal_valid` clears, new `done` 46 cycles later. `start` pulses while `busy` → ignored, `done` timing unchanged.
- **`AMP_CAL_MAJ_EN` glitch rejection:** a 1-cycle `cmp_in` glitch against the model during SAR_WAIT → result still 19. Without the macro, a glitch aligned to the decide sample → result differs.
